// File: rtl/uart_pkg.sv
// Shared UART definitions: handshake state encoding, default byte width and
// the baud divisor common to the receiver and transmitter.
package uart_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rx_hs_state_e;

    localparam int WL_DEFAULT = 8;
    localparam int BAUD_DIV   = 10418;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. Occupancy is tracked in a
// level register; the head of the queue is presented on a registered rd_data.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int WL    = WL_DEFAULT,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          push,
    input  logic [WL-1:0] wr_data,
    input  logic          pop,
    output logic [WL-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic          drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WL-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic [WL-1:0] rd_data_r;
    logic [WL-1:0] rd_data_nxt_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign empty_s   = (level_r == {LW{1'b0}});
    assign full_s    = (level_r == LW'(DEPTH));
    // A pop on an empty FIFO is ignored, so a push into an empty FIFO always wins.
    assign pop_ok_s  = pop & ~empty_s;
    assign push_ok_s = push & (~full_s | pop_ok_s);
    assign drop      = push & full_s & ~pop_ok_s;

    // Next level, next read pointer and next head-of-queue value.
    always_comb begin
        level_nxt_s   = level_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        rd_data_nxt_s = {WL{1'b0}};
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
        // The new head may be the slot being written this very edge.
        if (level_nxt_s == {LW{1'b0}}) begin
            rd_data_nxt_s = {WL{1'b0}};
        end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            rd_data_nxt_s = wr_data;
        end else begin
            rd_data_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Pointer, level and head registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= {LW{1'b0}};
            rd_data_r <= {WL{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r  <= rd_ptr_nxt_s;
            level_r   <= level_nxt_s;
            rd_data_r <= rd_data_nxt_s;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = rd_data_r;
    assign empty   = empty_s;
    assign full    = full_s;
    assign level   = level_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: acknowledges each byte over the rx_start/rx_finish level
// handshake, queues it in the byte FIFO and flags bytes dropped while full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WL    = WL_DEFAULT,
    parameter int DEPTH = 16,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [WL-1:0] rx_data,
    input  logic          rx_start,
    output logic          rx_finish,
    input  logic          rd_en,
    output logic [WL-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic          overflow,
    input  logic          clr_ovf
);

    rx_hs_state_e state_r;
    rx_hs_state_e state_nxt_s;
    logic         rx_finish_r;
    logic         rx_finish_nxt_s;
    logic         push_s;
    logic         drop_s;
    logic         overflow_r;
    logic         overflow_nxt_s;

    // Handshake next-state: capture only on the IDLE->ACK transition.
    always_comb begin
        state_nxt_s     = state_r;
        rx_finish_nxt_s = rx_finish_r;
        push_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_start) begin
                    push_s          = 1'b1;
                    state_nxt_s     = ST_ACK;
                    rx_finish_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_IDLE;
                    rx_finish_nxt_s = 1'b0;
                end
            end
            ST_ACK: begin
                if (!rx_start) begin
                    state_nxt_s     = ST_IDLE;
                    rx_finish_nxt_s = 1'b0;
                end else begin
                    state_nxt_s     = ST_ACK;
                    rx_finish_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                rx_finish_nxt_s = 1'b0;
            end
        endcase
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_comb begin
        overflow_nxt_s = overflow_r;
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // Handshake state and flag registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            rx_finish_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rx_finish_r <= rx_finish_nxt_s;
            overflow_r  <= overflow_nxt_s;
        end
    end

    uart_byte_fifo #(
        .WL    (WL),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (push_s),
        .wr_data (rx_data),
        .pop     (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level),
        .drop    (drop_s)
    );

    assign rx_finish = rx_finish_r;
    assign overflow  = overflow_r;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Downstream consumer of the UART receiver. Accepts each received byte over the receiver's level handshake (rx_start / rx_finish) and stores it in a synchronous first-word-fall-through FIFO. Application logic drains the FIFO at its own pace. Both blocks share the CLK domain, so no synchronisers are needed.

Parameters:
WL, 8, byte width; matches the receiver data width.
DEPTH, 16, FIFO entries; power of two, minimum 2.
LW, $clog2(DEPTH+1), width of the level output (derived, not overridden).

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST_N  input  1  synchronous reset, active-low.
rx_data  input  WL  received byte from the receiver; stable while rx_start=1.
rx_start  input  1  receiver "byte ready" level; held high until rx_finish is seen.
rx_finish  output  1  acknowledge to the receiver; level.
rd_en  input  1  pop request from the consumer.
rd_data  output  WL  head of FIFO (FWFT); 0 when empty.
empty  output  1  FIFO empty.
full  output  1  FIFO full.
level  output  LW  entries stored, 0..DEPTH.
overflow  output  1  sticky flag: a byte was dropped.
clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (RST_N=0 at an edge): state=IDLE, rx_finish=0, wr_ptr=rd_ptr=0, level=0, empty=1, full=0, overflow=0, rd_data=0. Memory contents are not reset.
- Handshake FSM, two states, all outputs registered:
  - IDLE: if rx_start=1, capture rx_data on this edge, go to ACK, and assert rx_finish=1 (visible next cycle).
  - ACK: hold rx_finish=1. When rx_start=0, go to IDLE and set rx_finish=0. No capture occurs in ACK, so one frame produces exactly one push.
- Push latency: empty deasserts, and the byte appears on rd_data, in the cycle after the capture edge.
- Capture while full: if rd_en=1 in the same cycle, pop and push both occur, full stays 1, and level is unchanged. Otherwise the byte is dropped, overflow is set to 1, and the handshake still completes (rx_finish asserted).
- Pop: rd_en=1 with empty=0 advances rd_ptr. rd_data shows the next head in the following cycle. rd_en with empty=1 is ignored; no flag and no pointer change.
- Simultaneous push and pop while not empty or full: level unchanged, both pointers advance.
- Simultaneous push and pop while empty: the push wins and the pop is ignored (FWFT head not yet valid); level becomes 1.
- Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0. full and empty are derived from the level register, not from pointer compare.
- overflow: set on a drop, cleared by clr_ovf=1. If both happen in the same cycle, set wins.
- Reset during ACK: return to IDLE with rx_finish=0. If rx_start is still high afterwards, the byte is captured again. This duplicate is accepted and documented.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE=1'b0, ACK=1'b1).
  - Default WL=8.
  - Baud divisor constant (10418) shared with the receiver and the future transmitter.
- One sub-module: uart_byte_fifo (storage, pointers, level, flags, FWFT read mux).
- The handshake FSM and overflow flag stay in the top module.

Test Plan:
1. Reset then idle: hold RST_N=0 for 3 cycles, release -> empty=1, level=0, rx_finish=0, rd_data=0.
2. Single byte: drive rx_data=8'hA5 and rx_start=1 until rx_finish=1, then drop rx_start.
   - rx_finish rises 1 cycle after capture and falls 1 cycle after rx_start=0.
   - Next cycle: empty=0, level=1, rd_data=8'hA5.
   - rd_en=1 for 1 cycle -> empty=1.
3. Fill and wrap:
   - Push 8'h00..8'h0F (DEPTH=16) -> full=1, level=16.
   - Pop 4 bytes (8'h00..8'h03); push 8'h10..8'h13.
   - Drain -> sequence 8'h04..8'h13 in order.
4. Overflow: with full=1, push 8'hEE and rd_en=0.
   - Handshake completes, overflow=1, level stays 16, 8'hEE never appears on rd_data.
   - clr_ovf=1 -> overflow=0.
5. Full with simultaneous pop: with full=1, push 8'h77 and rd_en=1 in the capture cycle.
   - level stays 16, full stays 1.
   - 8'h77 is the last byte drained.
6. Reset mid-handshake: assert RST_N=0 during ACK while rx_start=1.
   - rx_finish=0, level=0.
   - After release with rx_start still 1, the byte is captured once: level=1.
